// File: rtl/frame_sequencer.sv
// frame_sequencer: animation frame stepper with prescaled timing, pause/step and manual/auto animation switching
// Ports: clk/reset (async active-high); ena global freeze; anim_sel manual animation; auto_mode auto-advance
// after LOOPS loops; speed frame period scale; pause/step hold and single-step; limit frames of current animation.
// Outputs animation/frame registered indices; frame_tick marks a new frame value; loop_done marks a wrap to 0.
module frame_sequencer #(
  parameter int BASE_DIV = 1000000,
  parameter int DIV_W    = 24,
  parameter int LOOPS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [5:0] anim_sel,
  input  logic       auto_mode,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       step,
  input  logic [5:0] limit,
  output logic [5:0] animation,
  output logic [5:0] frame,
  output logic       frame_tick,
  output logic       loop_done
);
  localparam int LW = $clog2(LOOPS) + 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, SWITCH} state_t;
  state_t           r_state;
  logic [DIV_W-1:0] r_presc;
  logic [LW-1:0]    r_loops;
  logic [5:0]       r_animation, r_frame;
  logic             r_frame_tick, r_loop_done, r_auto_sw;
  logic [DIV_W-1:0] w_pmax;
  logic [5:0]       w_lmax;
  logic             w_tick, w_man, w_adv, w_wrap, w_last;
  assign w_pmax = DIV_W'(BASE_DIV * (int'(speed) + 1) - 1);
  // >= rather than == so lowering speed mid-count ticks immediately
  assign w_tick = r_presc >= w_pmax;
  assign w_man  = !auto_mode && anim_sel != r_animation;
  assign w_adv  = (r_state == RUN && !pause && w_tick) || (r_state == PAUSED && pause && step);
  // limit 0 is treated as a single-frame animation
  assign w_lmax = limit == 6'd0 ? 6'd0 : limit - 6'd1;
  assign w_wrap = r_frame >= w_lmax;
  assign w_last = r_loops == LW'(LOOPS - 1);
  assign animation  = r_animation;
  assign frame      = r_frame;
  assign frame_tick = r_frame_tick;
  assign loop_done  = r_loop_done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_loops      <= '0;
      r_animation  <= '0;
      r_frame      <= '0;
      r_frame_tick <= 1'b0;
      r_loop_done  <= 1'b0;
      r_auto_sw    <= 1'b0;
    end else if (!ena) begin
      r_state <= IDLE;
    end else begin
      r_frame_tick <= 1'b0;
      r_loop_done  <= 1'b0;
      if (!auto_mode) r_loops <= '0;
      case (r_state)
        IDLE: r_state <= pause ? PAUSED : RUN;
        SWITCH: begin
          r_animation  <= r_auto_sw ? r_animation + 6'd1 : anim_sel;
          r_frame      <= '0;
          r_presc      <= '0;
          r_loops      <= '0;
          r_frame_tick <= 1'b1;
          r_state      <= pause ? PAUSED : RUN;
        end
        default: begin
          // a manual switch request wins over any same-cycle tick or step
          if (w_man) begin
            r_state   <= SWITCH;
            r_auto_sw <= 1'b0;
          end else if (r_state == RUN && pause) begin
            r_state <= PAUSED;
          end else if (r_state == PAUSED && !pause) begin
            r_state <= RUN;
          end else begin
            if (r_state == RUN) r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
            if (w_adv) begin
              r_frame      <= w_wrap ? 6'd0 : r_frame + 6'd1;
              r_frame_tick <= 1'b1;
              r_loop_done  <= w_wrap;
              if (auto_mode && w_wrap) begin
                r_loops <= r_loops + LW'(1);
                if (w_last) begin
                  r_state   <= SWITCH;
                  r_auto_sw <= 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed vector bench for frame_sequencer
module tb_frame_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [5:0] anim_sel;
  logic       auto_mode;
  logic [2:0] speed;
  logic       pause;
  logic       step;
  logic [5:0] limit;
  logic [5:0] animation, frame;
  logic       frame_tick, loop_done;
  int tests = 0;
  int failed = 0;
  typedef struct {
    logic       ena;
    logic [5:0] sel;
    logic       am;
    logic [2:0] spd;
    logic       pz;
    logic       st;
    logic [5:0] lim;
    int         n;
    logic [5:0] ea, ef;
    logic       et, el;
  } vec_t;
  vec_t q[$];
  frame_sequencer #(.BASE_DIV(4), .DIV_W(8), .LOOPS(2)) dut (
    .clk(clk), .reset(reset), .ena(ena), .anim_sel(anim_sel), .auto_mode(auto_mode),
    .speed(speed), .pause(pause), .step(step), .limit(limit),
    .animation(animation), .frame(frame), .frame_tick(frame_tick), .loop_done(loop_done)
  );
  always #5 clk = ~clk;
  task automatic add(input logic e, input logic [5:0] s, input logic am, input logic [2:0] spd,
                     input logic pz, input logic st, input logic [5:0] lim, input int n,
                     input logic [5:0] ea, input logic [5:0] ef, input logic et, input logic el);
    vec_t v;
    v.ena = e; v.sel = s; v.am = am; v.spd = spd; v.pz = pz; v.st = st; v.lim = lim; v.n = n;
    v.ea = ea; v.ef = ef; v.et = et; v.el = el;
    q.push_back(v);
  endtask
  task automatic chk(input string name, input logic [5:0] ea, input logic [5:0] ef, input logic et, input logic el);
    tests++;
    if ({animation, frame, frame_tick, loop_done} !== {ea, ef, et, el}) begin
      failed++;
      $display("FAIL %s: got anim=%0d frame=%0d tick=%0b done=%0b, want anim=%0d frame=%0d tick=%0b done=%0b",
               name, animation, frame, frame_tick, loop_done, ea, ef, et, el);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; ena = 1'b0; anim_sel = '0; auto_mode = 1'b0; speed = '0;
    pause = 1'b0; step = 1'b0; limit = 6'd10;
    add(1, 0,0,0,0,0,10, 5,  0,1,1,0);
    add(1, 0,0,0,0,0,10, 1,  0,1,0,0);
    add(1, 0,0,0,0,0,10, 3,  0,2,1,0);
    add(1, 0,0,0,0,0,10, 28, 0,9,1,0);
    add(1, 0,0,0,0,0,10, 4,  0,0,1,1);
    add(1, 0,0,0,0,0,10, 1,  0,0,0,0);
    add(1, 0,0,2,0,0,10, 11, 0,1,1,0);
    add(1, 0,0,2,0,0,10, 11, 0,1,0,0);
    add(1, 0,0,2,0,0,10, 1,  0,2,1,0);
    add(1, 0,0,7,0,0,10, 20, 0,2,0,0);
    add(1, 0,0,0,0,0,10, 1,  0,3,1,0);
    add(1, 0,0,0,0,0,10, 1,  0,3,0,0);
    add(1, 0,0,0,1,0,10, 1,  0,3,0,0);
    add(1, 0,0,0,1,1,10, 1,  0,4,1,0);
    add(1, 0,0,0,1,0,10, 2,  0,4,0,0);
    add(1, 0,0,0,1,1,10, 1,  0,5,1,0);
    add(1, 0,0,0,1,0,10, 1,  0,5,0,0);
    add(1, 0,0,0,1,1,10, 1,  0,6,1,0);
    add(1, 0,0,0,1,0,10, 5,  0,6,0,0);
    add(1, 0,0,0,0,0,10, 1,  0,6,0,0);
    add(1, 0,0,0,0,0,10, 2,  0,6,0,0);
    add(1, 0,0,0,0,0,10, 1,  0,7,1,0);
    add(1, 0,0,0,0,0,10, 3,  0,7,0,0);
    add(1, 1,0,0,0,0,10, 1,  0,7,0,0);
    add(1, 1,0,0,0,0,10, 1,  1,0,1,0);
    add(1, 1,0,0,0,0,10, 3,  1,0,0,0);
    add(1, 1,0,0,0,0,10, 1,  1,1,1,0);
    add(1, 63,0,0,0,0,2, 2,  63,0,1,0);
    add(1, 63,1,0,0,0,2, 4,  63,1,1,0);
    add(1, 63,1,0,0,0,2, 4,  63,0,1,1);
    add(1, 63,1,0,0,0,2, 4,  63,1,1,0);
    add(1, 63,1,0,0,0,2, 4,  63,0,1,1);
    add(1, 63,1,0,0,0,2, 1,  0,0,1,0);
    add(1, 63,0,0,0,0,2, 1,  0,0,0,0);
    add(1, 63,0,0,0,0,2, 1,  63,0,1,0);
    add(1, 63,0,0,0,0,0, 4,  63,0,1,1);
    add(1, 63,0,0,0,0,0, 1,  63,0,0,0);
    add(0, 63,0,0,0,0,10, 5, 63,0,0,0);
    add(1, 63,0,0,0,0,10, 1, 63,0,0,0);
    add(1, 63,0,0,0,0,10, 2, 63,0,0,0);
    add(1, 63,0,0,0,0,10, 1, 63,1,1,0);
    add(1, 63,0,0,0,0,10, 16,63,5,1,0);
    add(1, 63,0,0,0,0,3, 4,  63,0,1,1);
    add(1, 63,0,0,0,1,3, 1,  63,0,0,0);
    add(1, 63,0,0,0,0,3, 2,  63,0,0,0);
    add(1, 63,0,0,0,0,3, 1,  63,1,1,0);
    tick(2);
    chk("reset", 0, 0, 0, 0);
    reset = 1'b0;
    foreach (q[i]) begin
      ena = q[i].ena; anim_sel = q[i].sel; auto_mode = q[i].am; speed = q[i].spd;
      pause = q[i].pz; step = q[i].st; limit = q[i].lim;
      tick(q[i].n);
      chk($sformatf("row%0d", i), q[i].ea, q[i].ef, q[i].et, q[i].el);
    end
    tick(2);
    #2 reset = 1'b1;
    #1 chk("rst_async", 0, 0, 0, 0);
    anim_sel = 6'd0; limit = 6'd10;
    tick(1);
    reset = 1'b0;
    tick(4);
    chk("rst_first_wait", 0, 0, 0, 0);
    tick(1);
    chk("rst_first_tick", 0, 1, 1, 0);
    anim_sel = 6'd5;
    tick(1);
    chk("sw_req", 0, 1, 0, 0);
    #3 reset = 1'b1;
    #1 chk("rst_mid_switch", 0, 0, 0, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("sw_after_rst", 5, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
